// File: rtl/cpu_pkg.sv
// Shared processor definitions: opcode set, accumulator source encodings,
// writeback FSM states and the ALU-opcode classifier used by the controller.
package cpu_pkg;

    localparam logic [3:0] OP_NOP  = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_NOR  = 4'b0011;
    localparam logic [3:0] OP_SHFR = 4'b1011;
    localparam logic [3:0] OP_SHFL = 4'b1100;

    localparam logic [1:0] SRC_ALU  = 2'b00;
    localparam logic [1:0] SRC_REG  = 2'b01;
    localparam logic [1:0] SRC_DATA = 2'b10;
    localparam logic [1:0] SRC_HOLD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_WRITE  = 2'd2,
        ST_DONE   = 2'd3
    } wb_state_t;

    function automatic logic is_alu_op(input logic [3:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_NOR, OP_SHFR, OP_SHFL: return 1'b1;
            default:                                  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/acc_writeback_unit_if.sv
// Controller/ALU-facing bundle of the accumulator writeback stage.
interface acc_writeback_unit_if #(parameter int WIDTH = 8);
    logic             start;
    logic [3:0]       op;
    logic [1:0]       acc_src;
    logic [WIDTH-1:0] alu_out;
    logic             alu_zero_flag;
    logic             alu_carry_out;
    logic [WIDTH-1:0] reg_in;
    logic [WIDTH-1:0] data_in;
    logic [3:0]       alu_select;
    logic [WIDTH-1:0] acc_q;
    logic             zero_q;
    logic             carry_q;
    logic             busy;
    logic             done;

    modport master (
        output start, op, acc_src, alu_out, alu_zero_flag, alu_carry_out, reg_in, data_in,
        input  alu_select, acc_q, zero_q, carry_q, busy, done
    );

    modport slave (
        input  start, op, acc_src, alu_out, alu_zero_flag, alu_carry_out, reg_in, data_in,
        output alu_select, acc_q, zero_q, carry_q, busy, done
    );
endinterface

// File: rtl/acc_writeback_unit_settle_timer.sv
// Loadable down-counter that stops at zero; times the ALU settle window.
module settle_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             dec,
    output logic             is_zero
);
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_value;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign is_zero = (cnt == '0);
endmodule

// File: rtl/acc_writeback_unit.sv
// Accumulator/flag owner behind the ALU: drives alu_select, waits for the
// result to settle, then writes ACC from ALU, REG or DATA.
module acc_writeback_unit
    import cpu_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int SETTLE_CYCLES  = 2,
    parameter bit LOAD_SETS_ZERO = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    acc_writeback_unit_if.slave  bus
);
    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES - 1);

    wb_state_t  state, next_state;
    logic [3:0] op_q;
    logic [1:0] src_q;
    logic       timer_load, timer_zero;
    logic [WIDTH-1:0] load_value;

    assign timer_load = (state == ST_IDLE) && bus.start && (bus.acc_src == SRC_ALU)
                        && is_alu_op(bus.op);

    settle_timer #(.CNT_W(4)) u_settle_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (timer_load),
        .load_value (SETTLE_INIT),
        .dec        (state == ST_SETTLE),
        .is_zero    (timer_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    if (bus.acc_src == SRC_ALU) begin
                        next_state = is_alu_op(bus.op) ? ST_SETTLE : ST_DONE;
                    end else if (bus.acc_src == SRC_HOLD) begin
                        next_state = ST_DONE;
                    end else begin
                        next_state = ST_WRITE;
                    end
                end
            end
            ST_SETTLE: if (timer_zero) next_state = ST_WRITE;
            ST_WRITE:  next_state = ST_DONE;
            default:   next_state = ST_IDLE;
        endcase
    end

    // Select stays on the latched op through WRITE so the result is stable at capture.
    always_comb begin
        bus.busy       = (state == ST_SETTLE) || (state == ST_WRITE);
        bus.done       = (state == ST_DONE);
        bus.alu_select = OP_NOP;
        if (((state == ST_SETTLE) || (state == ST_WRITE)) && (src_q == SRC_ALU)) begin
            bus.alu_select = op_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q  <= OP_NOP;
            src_q <= SRC_ALU;
        end else if ((state == ST_IDLE) && bus.start) begin
            op_q  <= bus.op;
            src_q <= bus.acc_src;
        end
    end

    assign load_value = (src_q == SRC_REG) ? bus.reg_in : bus.data_in;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.acc_q   <= '0;
            bus.zero_q  <= 1'b0;
            bus.carry_q <= 1'b0;
        end else if (state == ST_WRITE) begin
            if (src_q == SRC_ALU) begin
                bus.acc_q   <= bus.alu_out;
                bus.zero_q  <= bus.alu_zero_flag;
                bus.carry_q <= bus.alu_carry_out;
            end else if (src_q != SRC_HOLD) begin
                bus.acc_q <= load_value;
                if (LOAD_SETS_ZERO) bus.zero_q <= (load_value == '0);
            end
        end
    end
endmodule

// File: tb/tb_acc_writeback_unit.sv
// Scoreboard bench for acc_writeback_unit; a second instance runs with
// LOAD_SETS_ZERO=0 on identical stimulus.
module tb_acc_writeback_unit;
    import cpu_pkg::*;

    localparam int SC = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    acc_writeback_unit_if #(.WIDTH(8)) bus0 ();
    acc_writeback_unit_if #(.WIDTH(8)) bus1 ();

    acc_writeback_unit #(.WIDTH(8), .SETTLE_CYCLES(SC), .LOAD_SETS_ZERO(1'b1)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(bus0)
    );
    acc_writeback_unit #(.WIDTH(8), .SETTLE_CYCLES(SC), .LOAD_SETS_ZERO(1'b0)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(bus1)
    );

    // Reference 8-bit ALU: {zero, carry, result}, zero taken over the 9-bit result.
    function automatic logic [9:0] alu_calc(input logic [3:0] s, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] t;
        t = 9'h000;
        case (s)
            OP_ADD:  t = {1'b0, a} + {1'b0, b};
            OP_SUB:  t = {1'b0, a} - {1'b0, b};
            OP_NOR:  t = {1'b0, ~(a | b)};
            OP_SHFR: t = {a[0], 1'b0, a[7:1]};
            OP_SHFL: t = {a[7], a[6:0], 1'b0};
            default: t = 9'h000;
        endcase
        return {(t == 9'h000), t};
    endfunction

    logic [9:0] alu0, alu1;
    assign alu0 = alu_calc(bus0.alu_select, bus0.acc_q, bus0.reg_in);
    assign alu1 = alu_calc(bus1.alu_select, bus1.acc_q, bus1.reg_in);
    assign bus0.alu_out       = alu0[7:0];
    assign bus0.alu_carry_out = alu0[8];
    assign bus0.alu_zero_flag = alu0[9];
    assign bus1.alu_out       = alu1[7:0];
    assign bus1.alu_carry_out = alu1[8];
    assign bus1.alu_zero_flag = alu1[9];
    assign bus1.start   = bus0.start;
    assign bus1.op      = bus0.op;
    assign bus1.acc_src = bus0.acc_src;
    assign bus1.reg_in  = bus0.reg_in;
    assign bus1.data_in = bus0.data_in;

    typedef struct {
        logic [7:0] acc;
        logic       z;
        logic       c;
        logic       z1;
    } exp_t;

    exp_t sb[$];
    int n_cmp = 0;
    int n_bad = 0;
    int done_cnt = 0;
    int exp_done = 0;
    logic [7:0] m_acc = 8'h00;
    logic       m_z = 1'b0, m_c = 1'b0, m_z1 = 1'b0;

    always @(negedge clk) if (bus0.done === 1'b1) done_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic run_req(input logic [3:0] o, input logic [1:0] s, input logic [7:0] r,
                           input logic [7:0] d, input bit inject);
        logic [9:0] res;
        logic [7:0] v;
        bit valid, got;
        int lat_exp;
        exp_t e;
        valid = (s == SRC_ALU) && is_alu_op(o);
        lat_exp = 0;
        if (valid) begin
            res = alu_calc(o, m_acc, r);
            m_acc = res[7:0]; m_c = res[8]; m_z = res[9]; m_z1 = res[9];
            lat_exp = SC + 1;
        end else if (s == SRC_REG || s == SRC_DATA) begin
            v = (s == SRC_REG) ? r : d;
            m_acc = v; m_z = (v == 8'h00);
            lat_exp = 1;
        end
        sb.push_back('{m_acc, m_z, m_c, m_z1});
        exp_done++;

        @(negedge clk);
        chk("done_single_cycle", 32'(bus0.done), 32'd0);
        bus0.op = o; bus0.acc_src = s; bus0.reg_in = r; bus0.data_in = d; bus0.start = 1'b1;
        @(posedge clk);
        #1 bus0.start = 1'b0;
        got = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus0.done === 1'b1) begin
                chk("latency", 32'(i), 32'(lat_exp));
                chk("busy_in_done", 32'(bus0.busy), 32'd0);
                chk("sel_in_done", 32'(bus0.alu_select), 32'(OP_NOP));
                got = 1;
                break;
            end
            chk("busy_inflight", 32'(bus0.busy), 32'd1);
            chk("sel_inflight", 32'(bus0.alu_select), valid ? 32'(o) : 32'(OP_NOP));
            if (inject && i == 0) begin
                bus0.op = OP_ADD; bus0.start = 1'b1;
                @(posedge clk);
                #1 bus0.start = 1'b0; bus0.op = o;
            end
        end
        if (!got) chk("done_timeout", 32'd0, 32'd1);
        e = sb.pop_front();
        chk("acc", 32'(bus0.acc_q), 32'(e.acc));
        chk("zero", 32'(bus0.zero_q), 32'(e.z));
        chk("carry", 32'(bus0.carry_q), 32'(e.c));
        chk("acc_noload", 32'(bus1.acc_q), 32'(e.acc));
        chk("zero_noload", 32'(bus1.zero_q), 32'(e.z1));
        chk("carry_noload", 32'(bus1.carry_q), 32'(e.c));
    endtask

    initial begin
        bus0.start = 1'b0; bus0.op = OP_NOP; bus0.acc_src = SRC_ALU;
        bus0.reg_in = 8'h00; bus0.data_in = 8'h00;
        #1;
        chk("rst_acc", 32'(bus0.acc_q), 32'd0);
        chk("rst_zero", 32'(bus0.zero_q), 32'd0);
        chk("rst_carry", 32'(bus0.carry_q), 32'd0);
        chk("rst_sel", 32'(bus0.alu_select), 32'd0);
        chk("rst_busy", 32'(bus0.busy), 32'd0);
        chk("rst_done", 32'(bus0.done), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Reset in the middle of SETTLE
        run_req(OP_NOP, SRC_DATA, 8'h00, 8'h33, 1'b0);
        @(negedge clk);
        bus0.op = OP_ADD; bus0.acc_src = SRC_ALU; bus0.reg_in = 8'h01; bus0.start = 1'b1;
        @(posedge clk);
        #1 bus0.start = 1'b0;
        @(negedge clk);
        chk("mid_busy", 32'(bus0.busy), 32'd1);
        chk("mid_sel", 32'(bus0.alu_select), 32'(OP_ADD));
        #2 rst_n = 1'b0;
        #1;
        chk("arst_acc", 32'(bus0.acc_q), 32'd0);
        chk("arst_zero", 32'(bus0.zero_q), 32'd0);
        chk("arst_carry", 32'(bus0.carry_q), 32'd0);
        chk("arst_sel", 32'(bus0.alu_select), 32'd0);
        chk("arst_busy", 32'(bus0.busy), 32'd0);
        m_acc = 8'h00; m_z = 1'b0; m_c = 1'b0; m_z1 = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        chk("no_done_after_reset", 32'(done_cnt), 32'(exp_done));

        run_req(OP_NOP, SRC_DATA, 8'h00, 8'h80, 1'b0);
        run_req(OP_ADD, SRC_ALU, 8'h80, 8'h00, 1'b0);
        run_req(OP_NOP, SRC_DATA, 8'h00, 8'h05, 1'b0);
        run_req(OP_SUB, SRC_ALU, 8'h07, 8'h00, 1'b0);
        run_req(OP_NOP, SRC_ALU, 8'h00, 8'h00, 1'b0);
        run_req(OP_ADD, SRC_HOLD, 8'h11, 8'h22, 1'b0);
        run_req(4'b0111, SRC_ALU, 8'h01, 8'h00, 1'b0);
        run_req(4'b1111, SRC_ALU, 8'h01, 8'h00, 1'b0);
        run_req(OP_NOP, SRC_DATA, 8'h00, 8'h81, 1'b0);
        run_req(OP_SHFL, SRC_ALU, 8'h00, 8'h00, 1'b1);
        run_req(OP_NOP, SRC_REG, 8'h00, 8'h55, 1'b0);
        run_req(OP_NOP, SRC_DATA, 8'h00, 8'h0F, 1'b0);
        run_req(OP_SUB, SRC_ALU, 8'h0F, 8'h00, 1'b0);
        run_req(OP_NOR, SRC_ALU, 8'h00, 8'h00, 1'b0);
        run_req(OP_SHFR, SRC_ALU, 8'h00, 8'h00, 1'b0);
        run_req(OP_NOP, SRC_REG, 8'hA5, 8'h00, 1'b0);
        run_req(OP_NOR, SRC_ALU, 8'h0F, 8'h00, 1'b0);

        repeat (3) @(negedge clk);
        chk("done_count", 32'(done_cnt), 32'(exp_done));
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/acc_writeback_unit.md
Name: acc_writeback_unit

Overview:
- Downstream stage of the 8-bit ALU: owns the accumulator (ACC) and the zero/carry flag register.
- Drives the ALU select lines and holds them stable while the combinational ALU result settles. Then writes the selected source (ALU result, REG, or data bus) into ACC and updates flags.
- Talks to the controller FSM through a start/busy/done handshake.
- acc_q feeds the ALU A input; zero_q and carry_q feed the controller.

Parameters:
- WIDTH, 8, datapath width of ACC, REG and data inputs.
- SETTLE_CYCLES, 2, clock cycles alu_select is held before the ALU result is captured; legal values 1..15.
- LOAD_SETS_ZERO, 1, if 1, REG/DATA loads update zero_q from the loaded value; if 0, loads leave flags untouched.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  controller request; sampled only in IDLE.
- op  in  4  opcode for this request (NOP=0000, ADD=0001, SUB=0010, NOR=0011, SHFR=1011, SHFL=1100).
- acc_src  in  2  ACC source: 00 ALU, 01 REG, 10 DATA, 11 HOLD.
- alu_out  in  WIDTH  ALU result.
- alu_zero_flag  in  1  ALU zero flag.
- alu_carry_out  in  1  ALU carry flag.
- reg_in  in  WIDTH  REG value (also wired to ALU B input).
- data_in  in  WIDTH  immediate/memory data.
- alu_select  out  4  select driven to the ALU.
- acc_q  out  WIDTH  accumulator (drives ALU A input).
- zero_q  out  1  registered zero flag.
- carry_q  out  1  registered carry flag.
- busy  out  1  high while a request is in flight.
- done  out  1  one-cycle completion pulse.

Behaviour:
Clocking and reset:
- Single clock domain: clk, rising edge.
- Reset rst_n is asynchronous assert, active-low; all state is cleared immediately on assertion.
- Reset values: acc_q=0, zero_q=0, carry_q=0, alu_select=0000 (NOP), busy=0, done=0, state=IDLE, settle counter=0.
- Reset mid-operation discards the request; no done pulse is issued.

States: IDLE, SETTLE, WRITE, DONE.
- IDLE:
  - start=1 at edge E0 latches op and acc_src, and sets busy=1.
  - Next state:
    - src=ALU with a valid ALU op (ADD/SUB/NOR/SHFL/SHFR): SETTLE, with alu_select=op and counter=SETTLE_CYCLES-1.
    - src=ALU with any other op (including NOP): DONE, no state change.
    - src=REG or DATA: WRITE.
    - src=HOLD: DONE.
- SETTLE:
  - alu_select held at the latched op.
  - acc_q must not change (it is the ALU A operand).
  - Counter decrements each cycle; when it reads 0, the next state is WRITE.
- WRITE, one cycle, captures at the closing edge:
  - ALU source: acc_q<=alu_out, zero_q<=alu_zero_flag, carry_q<=alu_carry_out, all verbatim. No flag recomputation: SUB borrow arrives as carry=1, and zero reflects the 9-bit result.
  - REG/DATA source: acc_q<=value. zero_q<=(value==0) only when LOAD_SETS_ZERO=1. carry_q is held.
  - Next state: DONE.
- DONE:
  - done=1 for exactly one cycle, busy=0, alu_select returns to NOP.
  - Next state: IDLE.

Latency:
- ALU op: state is SETTLE from E0; WRITE is entered at E(SETTLE_CYCLES); ACC/flags update at E(SETTLE_CYCLES+1); done is high during the following cycle.
- REG/DATA load: ACC updates at E1; done is high after E1.
- NOP or HOLD: done is high after E0.

Handshake and boundaries:
- start in SETTLE, WRITE or DONE is ignored; it is not queued.
- start may be reasserted in the cycle after done and is accepted.
- busy=1 in SETTLE and WRITE; 0 in IDLE and DONE.
- Flags are never updated by NOP, HOLD, or unrecognised opcodes.
- Unrecognised opcode values (0100-1010, 1101-1111) with src=ALU behave as NOP.

Decomposition:
- Shared package cpu_pkg, holding:
  - the opcode constants, identical to the processor/ALU opcode set;
  - the acc_src encodings;
  - the state enum;
  - the is_alu_op(op) function, used by both this block and the controller.
- One natural sub-module, settle_timer: a loadable down-counter with a zero output.
- The remaining logic (FSM, ACC and flags) stays in acc_writeback_unit.

Test Plan:
- Reset: assert rst_n=0 mid-SETTLE -> acc_q=0x00, zero_q=0, carry_q=0, alu_select=0, busy=0 with no clock edge; no done afterwards.
- Load then ADD (with ALU model): DATA load 0x80, then ADD with reg_in=0x80, SETTLE_CYCLES=2 -> ACC=0x80 at E1. For the ADD: acc_q=0x00, carry_q=1, zero_q=0 at E3; done high exactly E3-E4.
- SUB borrow: ACC=0x05, reg_in=0x07, op=SUB -> acc_q=0xFE, carry_q=1, zero_q=0; alu_select=0010 for the whole SETTLE window.
- NOP/HOLD: preload flags carry=1/zero=0, issue op=NOP src=ALU, then src=HOLD -> acc and flags unchanged; done after E0 each time; alu_select stays 0000.
- Busy rejection: issue SHFL on ACC=0x81, pulse start with op=ADD during SETTLE -> request ignored. Result: acc_q=0x02, carry_q=1, single done pulse.
- Load zero: reg_in=0x00 src=REG, with carry_q=1 beforehand -> LOAD_SETS_ZERO=1 gives zero_q=1, carry_q=1; LOAD_SETS_ZERO=0 gives zero_q held.
